// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;
  localparam logic [31:0] END_PC_DEFAULT   = 32'd164;

  // True when an address lies beyond the last instruction of the program.
  function automatic logic past_end(input logic [31:0] addr, input logic [31:0] limit);
    return addr > limit;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller and memory.
interface fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus the buffer that parks a word fetched during a stall.
module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        capture,
  input  logic        use_hold,
  input  logic        flush,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      instr_q      <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      if (capture) begin
        hold_pc_q    <= pc_in;
        hold_instr_q <= instr_in;
      end
      // Flush beats stall; a stall keeps every field; otherwise load or bubble.
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!freeze) begin
        if (load) begin
          valid_q <= 1'b1;
          pc_q    <= pc_in;
          instr_q <= instr_in;
        end else if (use_hold) begin
          valid_q <= 1'b1;
          pc_q    <= hold_pc_q;
          instr_q <= hold_instr_q;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign if_valid = valid_q;
  assign if_pc    = pc_q;
  assign if_instr = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage controller: next-PC selection, instruction-memory handshake and halt detection.
module fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] END_PC   = END_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_cur,
  output logic [31:0]         pc_next,
  output logic                pc_freeze,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [31:0]         branch_addr,
  fetch_ctrl_if.master        imem,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic                halted
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        kill_q, kill_d;
  logic        hpend_q, hpend_d;

  logic        pc_load;
  logic        word_load;
  logic        capture;
  logic        use_hold;
  logic [31:0] pc_step;

  assign pc_step = pc_cur + PC_STEP;
  assign pc_next = branch_taken ? branch_addr : pc_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      hpend_q <= hpend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    kill_d    = kill_q;
    hpend_d   = hpend_q;
    pc_load   = 1'b0;
    word_load = 1'b0;
    capture   = 1'b0;
    use_hold  = 1'b0;
    case (state_q)
      FETCH: begin
        if (hpend_q) begin
          // Redirected past the end with a request in flight: drain it, then stop.
          if (imem.imem_ack) begin
            kill_d  = 1'b0;
            hpend_d = 1'b0;
            state_d = HALT;
          end
        end else if (branch_taken) begin
          pc_load = 1'b1;
          if (imem.imem_ack) begin
            addr_d = branch_addr;
            kill_d = 1'b0;
            if (past_end(branch_addr, END_PC)) state_d = HALT;
          end else begin
            // Keep the request address stable and drop its data when it lands.
            kill_d = 1'b1;
            if (past_end(branch_addr, END_PC)) hpend_d = 1'b1;
          end
        end else if (imem.imem_ack) begin
          if (kill_q) begin
            kill_d = 1'b0;
            addr_d = pc_cur;
          end else if (freeze) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            word_load = 1'b1;
            pc_load   = 1'b1;
            addr_d    = pc_next;
            if (past_end(pc_next, END_PC)) state_d = HALT;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          addr_d  = branch_addr;
          state_d = past_end(branch_addr, END_PC) ? HALT : FETCH;
        end else if (!freeze) begin
          use_hold = 1'b1;
          pc_load  = 1'b1;
          addr_d   = pc_next;
          state_d  = past_end(pc_next, END_PC) ? HALT : FETCH;
        end
      end
      HALT: begin
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem.imem_req  = !rst && (state_q == FETCH);
  assign imem.imem_addr = addr_q;
  assign pc_freeze      = rst || !pc_load;
  assign halted         = (state_q == HALT);

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (word_load),
    .capture  (capture),
    .use_hold (use_hold),
    .flush    (branch_taken && (state_q != HALT)),
    .freeze   (freeze),
    .pc_in    (addr_q + PC_STEP),
    .instr_in (imem.imem_rdata),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_instr (if_instr)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected IF/ID words are queued by the stimulus and consumed by a monitor.
module tb_fetch_ctrl;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_freeze;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cur       (pc_cur),
    .pc_next      (pc_next),
    .pc_freeze    (pc_freeze),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Memory: returns its address as data, acks after lat_wait waiting cycles.
  int lat_wait = 0;
  int wcnt;
  assign bus.imem_ack   = bus.imem_req && (wcnt >= lat_wait);
  assign bus.imem_rdata = bus.imem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else                                   wcnt <= 0;
  end

  // PC register the controller drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pc_cur <= 32'd0;
    else if (!pc_freeze) pc_cur <= pc_next;
  end

  logic freeze_s = 1'b0;
  always @(posedge clk) freeze_s <= freeze;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } xact_t;
  xact_t exp_q[$];
  xact_t mon_e;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [31:0] pc, input logic [31:0] instr);
    xact_t x;
    x.pc    = pc;
    x.instr = instr;
    exp_q.push_back(x);
  endfunction

  // A fresh IF/ID entry is one that is valid and was not held by a stall.
  always @(negedge clk) begin
    if (!rst && if_valid === 1'b1 && !freeze_s) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xact: got pc %h instr %h, required none", if_pc, if_instr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xact_pc", if_pc, mon_e.pc);
        chk("xact_instr", if_instr, mon_e.instr);
        $display("xact pc=%h instr=%h", if_pc, if_instr);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_pc_freeze", pc_freeze, 1'b1);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_halted", halted, 1'b0);
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    lat_wait     = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait sequential run.
    do_reset();
    for (int k = 1; k <= 6; k++) push(32'(4 * k), 32'(4 * k - 4));
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("seq_addr", bus.imem_addr, 32'(4 * k));
      chk("seq_pc_next", pc_next, 32'(4 * k + 4));
    end
    drained("seq_drained");

    // Stall during the ack cycle of a two-cycle memory.
    do_reset();
    lat_wait = 1;
    push(32'd4, 32'd0);
    push(32'd8, 32'd4);
    tick();
    chk("stall_ack", bus.imem_ack, 1'b1);
    freeze = 1'b1;
    tick();
    chk("stall_req", bus.imem_req, 1'b0);
    chk("stall_pc_freeze", pc_freeze, 1'b1);
    chk("stall_valid", if_valid, 1'b0);
    tick();
    chk("stall_pc", pc_cur, 32'd0);
    freeze = 1'b0;
    #1;
    chk("unstall_pc_freeze", pc_freeze, 1'b0);
    chk("unstall_pc_next", pc_next, 32'd4);
    tick();
    chk("unstall_req", bus.imem_req, 1'b1);
    chk("unstall_addr", bus.imem_addr, 32'd4);
    tick();
    tick();
    drained("stall_drained");

    // Branch while the request to 0x10 is outstanding.
    do_reset();
    push(32'd4, 32'd0);
    push(32'd8, 32'd4);
    push(32'd12, 32'd8);
    push(32'd16, 32'd12);
    push(32'h44, 32'h40);
    repeat (4) tick();
    lat_wait = 3;
    tick();
    chk("br_req", bus.imem_req, 1'b1);
    chk("br_addr0", bus.imem_addr, 32'h10);
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    #1;
    chk("br_pc_freeze", pc_freeze, 1'b0);
    chk("br_pc_next", pc_next, 32'h40);
    tick();
    branch_taken = 1'b0;
    chk("br_addr1", bus.imem_addr, 32'h10);
    chk("br_pc", pc_cur, 32'h40);
    chk("br_flush", if_valid, 1'b0);
    tick();
    chk("br_addr2", bus.imem_addr, 32'h10);
    tick();
    chk("br_addr3", bus.imem_addr, 32'h40);
    chk("br_killed", if_valid, 1'b0);
    lat_wait = 0;
    tick();
    drained("br_drained");

    // Branch in the same cycle as the ack.
    do_reset();
    push(32'd4, 32'd0);
    push(32'd8, 32'd4);
    push(32'h84, 32'h80);
    repeat (2) tick();
    branch_taken = 1'b1;
    branch_addr  = 32'h80;
    #1;
    chk("brack_ack", bus.imem_ack, 1'b1);
    chk("brack_pc_freeze", pc_freeze, 1'b0);
    tick();
    branch_taken = 1'b0;
    chk("brack_addr", bus.imem_addr, 32'h80);
    chk("brack_pc", pc_cur, 32'h80);
    chk("brack_flush", if_valid, 1'b0);
    tick();
    drained("brack_drained");

    // Run to the end of the program.
    do_reset();
    for (int k = 1; k <= 42; k++) push(32'(4 * k), 32'(4 * k - 4));
    repeat (41) tick();
    chk("end_not_halted", halted, 1'b0);
    chk("end_last_addr", bus.imem_addr, 32'd164);
    tick();
    chk("end_halted", halted, 1'b1);
    chk("end_req", bus.imem_req, 1'b0);
    chk("end_pc_freeze", pc_freeze, 1'b1);
    chk("end_pc", pc_cur, 32'd168);
    branch_taken = 1'b1;
    #1;
    chk("end_branch_ignored", pc_freeze, 1'b1);
    tick();
    branch_taken = 1'b0;
    chk("end_halted2", halted, 1'b1);
    chk("end_req2", bus.imem_req, 1'b0);
    chk("end_pc2", pc_cur, 32'd168);
    chk("end_bubble", if_valid, 1'b0);
    drained("end_drained");

    // Reset in the middle of an outstanding request.
    do_reset();
    push(32'd4, 32'd0);
    push(32'd8, 32'd4);
    push(32'd12, 32'd8);
    repeat (3) tick();
    lat_wait = 3;
    tick();
    chk("mid_req", bus.imem_req, 1'b1);
    chk("mid_addr", bus.imem_addr, 32'd12);
    drained("mid_drained");
    do_reset();
    push(32'd4, 32'd0);
    push(32'd8, 32'd4);
    repeat (2) tick();
    chk("restart_addr", bus.imem_addr, 32'd8);
    drained("restart_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the IF stage of the ARM pipeline. It computes the next PC (sequential +4 or branch redirect) for the PC register and runs the req/ack handshake to instruction memory. It also owns the IF/ID pipeline register, handling stall (freeze), flush (branch) and end-of-program halt. It consumes the PC register's current value and drives its load input and its freeze input.

## Interface
- RESET_PC, 32'd0: first fetch address; equals the PC register reset value
- END_PC, 32'd164: a PC advance to any address above this halts fetch
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_cur  in  32  current PC from the PC register
- pc_next  out  32  next PC to the PC register load input
- pc_freeze  out  1  high = PC register holds this cycle
- freeze  in  1  hazard stall from ID/hazard unit
- branch_taken  in  1  redirect request from EXE
- branch_addr  in  32  redirect target
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address; stable while imem_req high
- imem_ack  in  1  data valid; may arrive in the same cycle as the request
- imem_rdata  in  32  instruction word
- if_valid  out  1  IF/ID holds a real instruction
- if_pc  out  32  fetch address + 4
- if_instr  out  32  fetched instruction
- halted  out  1  sticky end-of-program flag

## Operation
- pc_next = branch_taken ? branch_addr : pc_cur + 4. The sum is 32-bit and wraps modulo 2^32.
- Internal registers:
  - addr_q: outstanding or next fetch address; drives imem_addr.
  - kill: discard the next ack.
  - hold_instr, hold_pc: buffer for a word that arrives during a stall.
- States:
  - FETCH: imem_req=1.
    - On ack with kill=0, branch_taken=0, freeze=0: load IF/ID with {1, addr_q+4, rdata}. PC advances (pc_freeze=0). addr_q <= pc_next.
    - On ack with freeze=1 (no branch, kill=0): store the word in the hold buffer and go to HOLD. PC holds. IF/ID holds.
    - On ack with kill=1: discard the word, clear kill, set addr_q <= pc_cur, stay in FETCH.
    - branch_taken without ack: PC loads branch_addr. kill <= 1. addr_q is unchanged so the request address stays stable.
    - branch_taken with ack: the word is discarded. PC loads branch_addr. addr_q <= branch_addr. kill is unchanged (0).
  - HOLD: imem_req=0.
    - freeze drops, no branch: IF/ID <= hold buffer. PC advances by +4. addr_q <= pc_next. Go to FETCH.
    - branch_taken: drop the buffer. PC loads branch_addr. addr_q <= branch_addr. Go to FETCH.
  - HALT: imem_req=0, pc_freeze=1, halted=1. Exit only through reset.
- Halt entry: any PC advance whose pc_next > END_PC (unsigned) goes to HALT instead of FETCH or HOLD.
  - If a request is still outstanding at that point (branch without ack), the controller first completes it with kill set, then enters HALT.
- IF/ID update, in priority order:
  1. branch_taken: if_valid <= 0 (flush).
  2. freeze: hold all IF/ID fields.
  3. accepted word: load it.
  4. otherwise: if_valid <= 0 (bubble); if_pc and if_instr hold their values.
- pc_freeze = 1 in every cycle that is not a PC advance or a branch redirect. In HALT, branch_taken is ignored.

## Timing
- Reset values: state FETCH, addr_q=RESET_PC, kill=0, if_valid=0, if_pc=0, if_instr=0, halted=0, hold buffer 0. While rst is high, imem_req=0 and pc_freeze=1.
- Latency from ack to IF/ID: 1 clock, registered at the ack edge.
- Throughput: 1 instruction per cycle with zero-wait memory (ack tied high).
- imem_addr and imem_req change only at clock edges. Once raised, imem_req stays high until the cycle of ack.
- Invariant outside kill and HALT: addr_q == pc_cur after every edge.
- Reset asserted mid-request: the outstanding transaction is abandoned, and memory must tolerate the request dropping.

## Structure
- Shared package `if_pkg`:
  - state enum {FETCH, HOLD, HALT}
  - PC_STEP = 32'd4
  - RESET_PC and END_PC defaults
- The hold buffer plus IF/ID register form a natural sub-module, `if_id_reg` (clk, rst, load, flush, freeze, pc_in, instr_in). The FSM and next-PC logic stay in `fetch_ctrl`.

## Test plan
- Zero-wait sequential run: ack=1, rdata=addr, no stalls.
  - if_pc sequence is 4, 8, 12, … with if_valid=1 from the second cycle after reset release.
  - pc_next = pc_cur+4 each cycle.
- 2-cycle-latency memory with freeze asserted during the ack cycle:
  - Word is held in HOLD and PC holds.
  - When freeze drops, IF/ID shows the word 1 cycle later and the next request is pc+4.
- Branch to 0x40 while a request to 0x10 is outstanding:
  - imem_addr stays 0x10 until ack.
  - That word is discarded, and the next request is 0x40.
  - if_valid=0 for the flushed slot.
- Branch coincident with ack: the word is discarded, PC=branch_addr, and the next request goes to branch_addr.
- Sequential run to END_PC=164:
  - Fetch of 164 completes.
  - The advance to 168 sets halted=1 and imem_req=0, and pc_freeze stays 1 thereafter.
- Reset pulse mid-request: all outputs return to reset values, and fetch restarts at RESET_PC.
